// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkg
// Purpose  : Shared word-stream constants, FSM state type and beat-count width
//            helper for the serializer/deserializer pair.
// Revision : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Width of a "beats minus one" field: max(1, clog2(WORD_W/out_w))
    function automatic int nbeats_w(input int out_w);
        int n_beats;
        int width;
        n_beats = WORD_W / out_w;
        width   = 1;
        for (int i = 1; i < 6; i++) begin
            if ((1 << i) < n_beats) width = i + 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ser_beat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : ser_beat_ctr
// Purpose  : Beat position counter for the serializer; flags the last beat
//            of the word currently being sent.
// Revision : 1.0 - initial release
// ============================================================================
module ser_beat_ctr #(
    parameter int NB_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_adv,
    input  logic [NB_W-1:0] i_nbeats,
    output logic            o_last_beat
);

    logic [NB_W-1:0] r_cnt;
    logic [NB_W-1:0] r_nb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_nb  <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_nb  <= i_nbeats;
        end else if (i_adv) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last_beat = (r_cnt == r_nb);

endmodule
`default_nettype wire

// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : stream_serializer
// Purpose  : Splits 32-bit valid/ready words into OUT_W-bit beats with a
//            per-beat frame-last flag. Define STREAM_SER_MSB_FIRST_EN to send
//            the most significant beat first (default: LSB first).
// Revision : 1.0 - initial release
// ============================================================================
module stream_serializer
    import stream_pkg::*;
#(
    parameter  int OUT_W = 8,
    localparam int NB_W  = nbeats_w(OUT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_data,
    input  logic [NB_W-1:0]   i_nbeats,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_last
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_sreg;
    logic              r_flag;
    logic              w_word_xfer;
    logic              w_beat_xfer;
    logic              w_last_beat;
    logic              w_load;
    logic              w_shift;
    logic [NB_W-1:0]   w_nbeats;

    // A full-width beat means every word is a single beat.
    generate
        if (OUT_W == WORD_W) begin : g_single_beat
            assign w_nbeats = i_nbeats & {NB_W{1'b0}};
        end else begin : g_multi_beat
            assign w_nbeats = i_nbeats;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_word_xfer) w_state_nxt = SEND;
            SEND:    if (w_beat_xfer && w_last_beat && !w_word_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ready on the final beat lets the next word reload with no bubble.
    always_comb begin
        o_valid     = (r_state == SEND);
        o_ready     = !rst && (!o_valid || (i_ready && w_last_beat));
        w_word_xfer = i_valid && o_ready;
        w_beat_xfer = o_valid && i_ready;
        w_load      = w_word_xfer;
        w_shift     = w_beat_xfer && !w_last_beat;
        o_last      = o_valid && r_flag && w_last_beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
            r_flag <= 1'b0;
        end else if (w_load) begin
            r_sreg <= i_data;
            r_flag <= i_last;
        end else if (w_shift) begin
`ifdef STREAM_SER_MSB_FIRST_EN
            r_sreg <= r_sreg << OUT_W;
`else
            r_sreg <= r_sreg >> OUT_W;
`endif
        end
    end

`ifdef STREAM_SER_MSB_FIRST_EN
    assign o_data = r_sreg[WORD_W-1 -: OUT_W];
`else
    assign o_data = r_sreg[OUT_W-1:0];
`endif

    ser_beat_ctr #(
        .NB_W (NB_W)
    ) u_beat_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_adv       (w_shift),
        .i_nbeats    (w_nbeats),
        .o_last_beat (w_last_beat)
    );

endmodule
`default_nettype wire
